cpu_stage_sequencer: RTL and testbench
======================================

// Module: cpu_stage_sequencer
// PURPOSE
//  Multicycle stage sequencer for the single-issue CPU. Owns the PC and the latched instruction register.
//  Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the IM, DM, register-file and ALU enables.
//  Sits between the instruction/data memories and the p3 datapath, replacing free-running tick sequencing.
//  Adds ready handshakes, halt and timeout error detection.
// PARAMETERS
//  DataSize  32  instruction/data word width
//  MemSize   10  PC width (IM word address)
//  WAIT_MAX  8   max cycles to wait for im_ready/dm_ready before error (>=1)
//  HALT_WORD 32'hFFFF_FFFF  instruction encoding that halts the core
// PORTS
//  clk                 in   1         clock, all state on rising edge
//  reset               in   1         synchronous, active-low reset
//  start               in   1         1-cycle pulse: begin execution at PC=0
//  halt_req            in   1         request halt at next instruction boundary
//  instruction         in   DataSize  IM read data, valid when im_ready=1
//  im_ready            in   1         IM read data valid this cycle
//  dm_ready            in   1         DM access complete this cycle
//  PC                  out  MemSize   current instruction address
//  IM_enable, IM_read  out  1         IM access strobes
//  DM_enable           out  1         DM access strobe
//  DM_read, DM_write   out  1         DM direction strobes
//  enable_reg_read     out  1         register-file read strobe
//  enable_alu_execute  out  1         ALU execute strobe
//  enable_reg_write    out  1         register-file write-back strobe
//  ir                  out  DataSize  latched instruction
//  state               out  3         current FSM state encoding
//  busy                out  1         1 in FETCH..WB
//  halted              out  1         1 in HALT
//  timeout_err         out  1         1 in ERR
// BEHAVIOUR
//  Reset (reset=0 at edge, any state):
//   state=IDLE, PC=0, ir=0, wait_cnt=0, halt_pend=0.
//   All strobes, busy, halted and timeout_err read 0.
//  Outputs: strobes, busy, halted and timeout_err are Moore decodes of the registered state and ir.
//  Encoding: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6 ERR=7.
//  Instruction class: opcode=ir[30:25]; 6'b000010=LOAD, 6'b001010=STORE, everything else is ALU.
//  IDLE: no strobes. start=1 -> FETCH with PC=0.
//  FETCH: IM_enable=IM_read=1.
//   - im_ready=1: ir<=instruction, go to DECODE.
//   - else wait_cnt++. wait_cnt==WAIT_MAX-1 without ready -> ERR.
//  DECODE: enable_reg_read=1 for one cycle. ir==HALT_WORD -> HALT (PC not advanced); else -> EXEC.
//  EXEC: enable_alu_execute=1 for one cycle. LOAD/STORE -> MEM; ALU -> WB.
//  MEM: DM_enable=1; DM_read=1 for LOAD, DM_write=1 for STORE (never both).
//   - dm_ready=1 on LOAD -> WB.
//   - dm_ready=1 on STORE: PC<=PC+1, then FETCH (or HALT if halt_pend).
//   - Timeout rule same as FETCH -> ERR.
//  WB: enable_reg_write=1 for one cycle. PC<=PC+1; then FETCH, or HALT if halt_pend.
//  wait_cnt clears on every state change.
//  halt_req: sets sticky halt_pend in any busy state. Taken only at the instruction boundary
//   (end of WB / STORE completion); the current instruction always finishes.
//   halt_req in IDLE is ignored.
//  HALT: halted=1, PC holds. start -> FETCH with PC=0, halt_pend=0.
//  ERR: timeout_err=1 and sticky; start is ignored; only reset exits.
//  PC arithmetic: modulo 2^MemSize; 2^MemSize-1 +1 wraps to 0 with no flag.
//  Latency with ready in the first cycle:
//   - ALU and STORE: 4 cycles.
//   - LOAD: 5 cycles.
//   - Each ready-wait cycle adds 1.
//  start while busy is ignored.
//  Simultaneous reset=0 with start/halt_req: reset wins.
// TESTING
//  1. Reset, start, ALU word 32'h4000_0000 with im_ready=1 -> strobes FETCH,DECODE,EXEC,WB on consecutive cycles; PC 0->1 after 4 cycles.
//  2. LOAD 32'h0400_0000, dm_ready delayed 2 cycles -> DM_read=DM_enable=1 for 3 cycles, then enable_reg_write for 1 cycle; PC=1 after 7 cycles total.
//  3. STORE 32'h1400_0000, dm_ready=1 -> DM_write=1 for 1 cycle, no enable_reg_write; FETCH resumes with PC=1.
//  4. halt_req pulsed during EXEC of an ALU instruction -> WB completes, PC=1, next state HALT, halted=1; start -> FETCH with PC=0.
//  5. im_ready held 0 for WAIT_MAX=8 cycles -> state ERR, timeout_err=1; start has no effect; reset=0 -> IDLE with all outputs 0.
//  6. Preload PC=1023 via 1023 ALU instructions, run one more -> PC wraps to 0. Also: fetching HALT_WORD -> HALT with PC unchanged.

Source files
------------

// File: rtl/cpu_stage_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the single-issue CPU.
// Owns PC and the instruction register; every output is a registered decode of the next state.
module cpu_stage_sequencer #(
    parameter int                  DataSize  = 32,
    parameter int                  MemSize   = 10,
    parameter int                  WAIT_MAX  = 8,
    parameter logic [DataSize-1:0] HALT_WORD = {DataSize{1'b1}}
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                halt_req,
    input  logic [DataSize-1:0] instruction,
    input  logic                im_ready,
    input  logic                dm_ready,
    output logic [MemSize-1:0]  PC,
    output logic                IM_enable,
    output logic                IM_read,
    output logic                DM_enable,
    output logic                DM_read,
    output logic                DM_write,
    output logic                enable_reg_read,
    output logic                enable_alu_execute,
    output logic                enable_reg_write,
    output logic [DataSize-1:0] ir,
    output logic [2:0]          state,
    output logic                busy,
    output logic                halted,
    output logic                timeout_err
);

    localparam int                 WCW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WCW-1:0]     WAIT_LAST = WCW'(WAIT_MAX - 1);
    localparam logic [WCW-1:0]     WAIT_ONE  = WCW'(1);
    localparam logic [MemSize-1:0] PC_ONE    = MemSize'(1);
    localparam logic [5:0]         OPC_LOAD  = 6'b000010;
    localparam logic [5:0]         OPC_STORE = 6'b001010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    typedef struct packed {
        logic im_enable;
        logic im_read;
        logic dm_enable;
        logic dm_read;
        logic dm_write;
        logic reg_read;
        logic alu_execute;
        logic reg_write;
        logic busy;
        logic halted;
        logic timeout_err;
    } strobe_t;

    localparam strobe_t STROBE_NONE = strobe_t'({$bits(strobe_t){1'b0}});

    function automatic logic is_load(input logic [DataSize-1:0] w);
        return w[30:25] == OPC_LOAD;
    endfunction

    function automatic logic is_store(input logic [DataSize-1:0] w);
        return w[30:25] == OPC_STORE;
    endfunction

    function automatic strobe_t decode_strobes(input state_t st, input logic [DataSize-1:0] w);
        strobe_t s;
        s = STROBE_NONE;
        case (st)
            ST_FETCH:  begin s.im_enable = 1'b1; s.im_read = 1'b1; s.busy = 1'b1; end
            ST_DECODE: begin s.reg_read = 1'b1; s.busy = 1'b1; end
            ST_EXEC:   begin s.alu_execute = 1'b1; s.busy = 1'b1; end
            ST_MEM:    begin
                s.dm_enable = 1'b1;
                s.dm_read   = is_load(w);
                s.dm_write  = is_store(w);
                s.busy      = 1'b1;
            end
            ST_WB:     begin s.reg_write = 1'b1; s.busy = 1'b1; end
            ST_HALT:   s.halted = 1'b1;
            ST_ERR:    s.timeout_err = 1'b1;
            default:   s = STROBE_NONE;
        endcase
        return s;
    endfunction

    state_t                state_r, state_nxt_s;
    logic [MemSize-1:0]    pc_r, pc_nxt_s;
    logic [DataSize-1:0]   ir_r, ir_nxt_s;
    logic [WCW-1:0]        wait_cnt_r, wait_cnt_nxt_s;
    logic                  halt_pend_r, halt_pend_nxt_s;
    logic                  halt_now_s;
    logic                  wait_hit_s;
    strobe_t               strobe_r;

    // Next-state, PC, IR, wait counter and halt-pending logic.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        ir_nxt_s    = ir_r;
        wait_hit_s  = (wait_cnt_r == WAIT_LAST);
        // A request arriving in the boundary cycle itself is honoured at that boundary.
        halt_now_s  = halt_pend_r | halt_req;
        if (strobe_r.busy && halt_req) begin
            halt_pend_nxt_s = 1'b1;
        end else begin
            halt_pend_nxt_s = halt_pend_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_FETCH;
                    pc_nxt_s    = {MemSize{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (im_ready) begin
                    ir_nxt_s    = instruction;
                    state_nxt_s = ST_DECODE;
                end else if (wait_hit_s) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: state_nxt_s = (ir_r == HALT_WORD) ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_nxt_s = (is_load(ir_r) || is_store(ir_r)) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dm_ready) begin
                    if (is_store(ir_r)) begin
                        pc_nxt_s    = pc_r + PC_ONE;
                        state_nxt_s = halt_now_s ? ST_HALT : ST_FETCH;
                    end else begin
                        state_nxt_s = ST_WB;
                    end
                end else if (wait_hit_s) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_MEM;
                end
            end
            ST_WB: begin
                pc_nxt_s    = pc_r + PC_ONE;
                state_nxt_s = halt_now_s ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                if (start) begin
                    state_nxt_s     = ST_FETCH;
                    pc_nxt_s        = {MemSize{1'b0}};
                    halt_pend_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            ST_ERR:  state_nxt_s = ST_ERR;
            default: state_nxt_s = ST_ERR;
        endcase
        if (state_nxt_s != state_r) begin
            wait_cnt_nxt_s = {WCW{1'b0}};
        end else if (state_r == ST_FETCH || state_r == ST_MEM) begin
            wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
        end else begin
            wait_cnt_nxt_s = {WCW{1'b0}};
        end
    end

    // State registers and registered output strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            pc_r        <= {MemSize{1'b0}};
            ir_r        <= {DataSize{1'b0}};
            wait_cnt_r  <= {WCW{1'b0}};
            halt_pend_r <= 1'b0;
            strobe_r    <= STROBE_NONE;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            ir_r        <= ir_nxt_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            halt_pend_r <= halt_pend_nxt_s;
            strobe_r    <= decode_strobes(state_nxt_s, ir_nxt_s);
        end
    end

    assign PC                 = pc_r;
    assign ir                 = ir_r;
    assign state              = state_r;
    assign IM_enable          = strobe_r.im_enable;
    assign IM_read            = strobe_r.im_read;
    assign DM_enable          = strobe_r.dm_enable;
    assign DM_read            = strobe_r.dm_read;
    assign DM_write           = strobe_r.dm_write;
    assign enable_reg_read    = strobe_r.reg_read;
    assign enable_alu_execute = strobe_r.alu_execute;
    assign enable_reg_write   = strobe_r.reg_write;
    assign busy               = strobe_r.busy;
    assign halted             = strobe_r.halted;
    assign timeout_err        = strobe_r.timeout_err;

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Self-checking bench for cpu_stage_sequencer: directed vector table, hand-written corner
// sequences, and randomized instruction streams checked against a latency-rule model.
module tb_cpu_stage_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_ERR = 3'd7;
    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
    localparam logic [31:0] ALU_W = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset, start, halt_req, im_ready, dm_ready;
    logic [31:0] instruction;
    logic [9:0]  PC;
    logic        IM_enable, IM_read, DM_enable, DM_read, DM_write;
    logic        enable_reg_read, enable_alu_execute, enable_reg_write;
    logic [31:0] ir;
    logic [2:0]  state;
    logic        busy, halted, timeout_err;
    logic [10:0] obs;

    int n_checks = 0;
    int n_fail   = 0;
    int pc_m     = 0;

    cpu_stage_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .instruction(instruction), .im_ready(im_ready), .dm_ready(dm_ready),
        .PC(PC), .IM_enable(IM_enable), .IM_read(IM_read), .DM_enable(DM_enable),
        .DM_read(DM_read), .DM_write(DM_write), .enable_reg_read(enable_reg_read),
        .enable_alu_execute(enable_alu_execute), .enable_reg_write(enable_reg_write),
        .ir(ir), .state(state), .busy(busy), .halted(halted), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    assign obs = {IM_enable, IM_read, DM_enable, DM_read, DM_write, enable_reg_read,
                  enable_alu_execute, enable_reg_write, busy, halted, timeout_err};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // cls: 0 = ALU, 1 = LOAD, 2 = STORE
    function automatic logic [10:0] exp_strobes(input logic [2:0] st, input int cls);
        case (st)
            S_FETCH:  return 11'b110_0000_0100;
            S_DECODE: return 11'b000_0010_0100;
            S_EXEC:   return 11'b000_0001_0100;
            S_MEM:    return {3'b001, cls == 1, cls == 2, 6'b000100};
            S_WB:     return 11'b000_0000_1100;
            S_HALT:   return 11'b000_0000_0010;
            S_ERR:    return 11'b000_0000_0001;
            default:  return 11'b000_0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] gen_word(input int cls);
        logic [31:0] w;
        w = $urandom;
        if (cls == 1) w[30:25] = 6'b000010;
        else if (cls == 2) w[30:25] = 6'b001010;
        else begin
            while (w[30:25] == 6'b000010 || w[30:25] == 6'b001010) w[30:25] = 6'($urandom);
            if (w == HALT_W) w[0] = 1'b0;
        end
        return w;
    endfunction

    typedef struct {
        logic [31:0] word;
        int          im_wait;
        int          dm_wait;
        int          halt_at;
        int          exp_cycles;
        int          exp_pc;
        int          exp_rw;
        int          exp_rd;
        int          exp_wr;
        logic [2:0]  exp_next;
    } vec_t;

    vec_t vecs[8];

    // Runs one instruction from its first FETCH cycle, reacting to the DUT's state.
    task automatic run_vec(input vec_t v);
        int cyc, fc, mc, rw, rd, wr;
        logic [2:0] prev;
        bit done;
        cyc = 0; fc = 0; mc = 0; rw = 0; rd = 0; wr = 0; done = 1'b0; prev = S_IDLE;
        check("vec_first_fetch", state, S_FETCH);
        for (int t = 0; t < 40 && !done; t++) begin
            if (t > 0 && ((state == S_FETCH && prev != S_FETCH) || state == S_HALT ||
                          state == S_ERR || state == S_IDLE)) begin
                done = 1'b1;
            end else begin
                if (enable_reg_write) rw++;
                if (DM_read) rd++;
                if (DM_write) wr++;
                im_ready    = (state == S_FETCH) && (fc == v.im_wait);
                instruction = im_ready ? v.word : $urandom;
                dm_ready    = (state == S_MEM) && (mc == v.dm_wait);
                halt_req    = (cyc == v.halt_at);
                if (state == S_FETCH) fc++;
                if (state == S_MEM) mc++;
                prev = state;
                cyc++;
                @(negedge clk);
            end
        end
        im_ready = 1'b0; dm_ready = 1'b0; halt_req = 1'b0;
        check("vec_boundary_reached", done, 1'b1);
        check("vec_cycles", cyc, v.exp_cycles);
        check("vec_pc", PC, v.exp_pc);
        check("vec_reg_write_cycles", rw, v.exp_rw);
        check("vec_dm_read_cycles", rd, v.exp_rd);
        check("vec_dm_write_cycles", wr, v.exp_wr);
        check("vec_next_state", state, v.exp_next);
    endtask

    // Expected per-cycle trace derived from the latency rules: FETCH for k+1, DECODE, EXEC,
    // MEM for m+1 (LOAD/STORE), WB (not STORE); PC advances by one at the boundary.
    task automatic run_model(input int cls, input int k, input int m, input bit do_halt);
        logic [2:0]  q[$];
        logic [31:0] word;
        int fi, mi, h;
        word = gen_word(cls);
        for (int i = 0; i <= k; i++) q.push_back(S_FETCH);
        q.push_back(S_DECODE);
        q.push_back(S_EXEC);
        if (cls != 0) for (int i = 0; i <= m; i++) q.push_back(S_MEM);
        if (cls != 2) q.push_back(S_WB);
        h  = $urandom_range(0, q.size() - 1);
        fi = 0; mi = 0;
        foreach (q[c]) begin
            check("rnd_state", state, q[c]);
            check("rnd_pc", PC, pc_m);
            check("rnd_strobes", obs, exp_strobes(q[c], cls));
            if (q[c] != S_FETCH) check("rnd_ir", ir, word);
            im_ready    = (q[c] == S_FETCH) ? (fi == k) : 1'($urandom_range(0, 1));
            instruction = (q[c] == S_FETCH && fi == k) ? word : $urandom;
            dm_ready    = (q[c] == S_MEM) ? (mi == m) : 1'($urandom_range(0, 1));
            halt_req    = do_halt && (c == h);
            start       = ($urandom_range(0, 3) == 0);
            if (q[c] == S_FETCH) fi++;
            if (q[c] == S_MEM) mi++;
            @(negedge clk);
        end
        pc_m = (pc_m + 1) % 1024;
        start = 1'b0; halt_req = 1'b0; im_ready = 1'b0; dm_ready = 1'b0;
        if (do_halt) begin
            for (int i = 0; i <= $urandom_range(0, 2); i++) begin
                check("rnd_halt_state", state, S_HALT);
                check("rnd_halt_pc", PC, pc_m);
                check("rnd_halt_strobes", obs, exp_strobes(S_HALT, 0));
                halt_req = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            halt_req = 1'b0;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            pc_m = 0;
        end
    endtask

    initial begin
        vecs[0] = '{32'h4000_0000, 0, 0, -1, 4, 1, 1, 0, 0, S_FETCH};
        vecs[1] = '{32'h0400_0000, 0, 2, -1, 7, 2, 1, 3, 0, S_FETCH};
        vecs[2] = '{32'h1400_0000, 0, 0, -1, 4, 3, 0, 0, 1, S_FETCH};
        vecs[3] = '{32'h4000_0000, 0, 0,  2, 4, 4, 1, 0, 0, S_HALT};
        vecs[4] = '{32'h4000_0000, 3, 0, -1, 7, 1, 1, 0, 0, S_FETCH};
        vecs[5] = '{32'h1400_0000, 1, 3, -1, 8, 2, 0, 0, 4, S_FETCH};
        vecs[6] = '{32'h0400_0000, 7, 0, -1, 12, 3, 1, 1, 0, S_FETCH};
        vecs[7] = '{32'h1400_0000, 0, 7, -1, 11, 4, 0, 0, 8, S_FETCH};

        reset = 1'b0; start = 1'b0; halt_req = 1'b0; im_ready = 1'b0; dm_ready = 1'b0;
        instruction = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_state", state, S_IDLE);
        check("reset_pc", PC, 10'd0);
        check("reset_ir", ir, 32'd0);
        check("reset_strobes", obs, 11'd0);

        // Reset held together with start and halt_req: reset wins.
        start = 1'b1; halt_req = 1'b1;
        @(negedge clk);
        check("reset_wins_state", state, S_IDLE);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        check("idle_halt_req_state", state, S_IDLE);
        check("idle_strobes", obs, 11'd0);
        halt_req = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_pc", PC, 10'd0);

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
            if (vecs[i].exp_next == S_HALT) begin
                check("vec_halted_flag", halted, 1'b1);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end

        pc_m = 4;
        for (int n = 0; n < 80; n++) begin
            run_model($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 5) == 0));
        end

        // Fetching the halt word: DECODE then HALT, PC not advanced.
        check("hw_fetch_state", state, S_FETCH);
        im_ready = 1'b1; instruction = HALT_W;
        @(negedge clk);
        im_ready = 1'b0;
        check("hw_decode_state", state, S_DECODE);
        check("hw_ir", ir, HALT_W);
        @(negedge clk);
        check("hw_halt_state", state, S_HALT);
        check("hw_halt_pc", PC, pc_m);
        check("hw_halt_strobes", obs, exp_strobes(S_HALT, 0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hw_restart_state", state, S_FETCH);
        check("hw_restart_pc", PC, 10'd0);

        // IM never ready: eight FETCH cycles then sticky ERR that ignores start.
        for (int i = 0; i < 8; i++) begin
            check("to_fetch_state", state, S_FETCH);
            @(negedge clk);
        end
        check("to_err_state", state, S_ERR);
        check("to_err_strobes", obs, exp_strobes(S_ERR, 0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("to_start_ignored", state, S_ERR);
        check("to_err_sticky", timeout_err, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("to_reset_state", state, S_IDLE);
        check("to_reset_strobes", obs, 11'd0);
        check("to_reset_ir", ir, 32'd0);
        check("to_reset_pc", PC, 10'd0);

        // PC wrap: 1023 ALU instructions reach 1023, one more wraps to 0.
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        im_ready = 1'b1; instruction = ALU_W;
        repeat (4 * 1023) @(negedge clk);
        check("wrap_pc_1023", PC, 10'd1023);
        check("wrap_state_1023", state, S_FETCH);
        repeat (4) @(negedge clk);
        check("wrap_pc_0", PC, 10'd0);
        check("wrap_state_0", state, S_FETCH);
        im_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
